// File: rtl/jtag_host_if.sv
// rtl/jtag_host_if.sv - command/response handshake bundle for the JTAG host
interface jtag_host_if #(
    parameter int MAXLEN = 32
) ();
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [1:0]                   cmd_op;
    logic [$clog2(MAXLEN+1)-1:0]  cmd_len;
    logic [MAXLEN-1:0]            cmd_data;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [MAXLEN-1:0]            rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - JTAG TAP master: scans IR/DR from a command queue, returns TDO
module jtag_host #(
    parameter int MAXLEN = 32,
    parameter int CLKDIV = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    jtag_host_if.slave   bus,
    output logic         tck,
    output logic         tms,
    output logic         tdi,
    input  logic         tdo
);
    localparam int LW = $clog2(MAXLEN + 1);
    localparam int CW = (LW > 3) ? LW : 3;
    localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAXLEN);

    typedef enum logic [2:0] {RSTSEQ, IDLE, HEAD, SHIFT, TAIL, RESP} state_t;

    state_t              r_state, w_state, w_adv_state;
    logic [CW-1:0]       r_cnt, w_cnt, w_adv_cnt;
    logic [DW-1:0]       r_div, w_div;
    logic                r_tck, w_tck, r_tms, w_tms, r_tdi, w_tdi;
    logic                r_op_ir, w_op_ir;
    logic [CW-1:0]       r_len, w_len;
    logic [MAXLEN-1:0]   r_data, w_data;
    logic [MAXLEN-1:0]   r_rsp_data, w_rsp_data;
    logic                r_rsp_valid, w_rsp_valid;
    logic                r_rsp_req, w_rsp_req;
    logic                w_illegal;

    // TMS value for TCK number c of segment s
    function automatic logic tms_of(input state_t s, input logic [CW-1:0] c,
                                    input logic ir, input logic [CW-1:0] len);
        case (s)
            RSTSEQ:  return c < CW'(5);
            HEAD:    return ir ? (c < CW'(2)) : (c == '0);
            SHIFT:   return c == (len - CW'(1));
            TAIL:    return c == '0;
            default: return 1'b0;
        endcase
    endfunction

    assign w_illegal = (bus.cmd_op == 2'b11) || (bus.cmd_len == '0) ||
                       (bus.cmd_len > LEN_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RSTSEQ;
            r_cnt       <= '0;
            r_div       <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_op_ir     <= 1'b0;
            r_len       <= '0;
            r_data      <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_req   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_div       <= w_div;
            r_tck       <= w_tck;
            r_tms       <= w_tms;
            r_tdi       <= w_tdi;
            r_op_ir     <= w_op_ir;
            r_len       <= w_len;
            r_data      <= w_data;
            r_rsp_data  <= w_rsp_data;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_req   <= w_rsp_req;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_div       = r_div;
        w_tck       = r_tck;
        w_tms       = r_tms;
        w_tdi       = r_tdi;
        w_op_ir     = r_op_ir;
        w_len       = r_len;
        w_data      = r_data;
        w_rsp_data  = r_rsp_data;
        w_rsp_valid = r_rsp_valid;
        w_rsp_req   = r_rsp_req;
        w_adv_state = r_state;
        w_adv_cnt   = r_cnt + CW'(1);

        // Where the TCK after the current one belongs
        case (r_state)
            RSTSEQ: if (r_cnt == CW'(5)) begin
                w_adv_state = r_rsp_req ? RESP : IDLE;
                w_adv_cnt   = '0;
            end
            HEAD: if (r_cnt == (r_op_ir ? CW'(3) : CW'(2))) begin
                w_adv_state = SHIFT;
                w_adv_cnt   = '0;
            end
            SHIFT: if (r_cnt == (r_len - CW'(1))) begin
                w_adv_state = TAIL;
                w_adv_cnt   = '0;
            end
            TAIL: if (r_cnt == CW'(1)) begin
                w_adv_state = RESP;
                w_adv_cnt   = '0;
            end
            default: ;
        endcase

        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_op_ir    = (bus.cmd_op == 2'b01);
                    w_len      = CW'(bus.cmd_len);
                    w_data     = bus.cmd_data;
                    w_rsp_data = '0;
                    w_div      = '0;
                    w_cnt      = '0;
                    if (w_illegal) begin
                        w_state     = RESP;
                        w_rsp_valid = 1'b1;
                    end else begin
                        w_state   = (bus.cmd_op == 2'b00) ? RSTSEQ : HEAD;
                        w_rsp_req = 1'b1;
                        w_tms     = 1'b1;
                        w_tdi     = 1'b0;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state     = IDLE;
                    w_rsp_valid = 1'b0;
                    w_rsp_req   = 1'b0;
                end
            end
            default: begin
                if (r_div != DIV_LAST) begin
                    w_div = r_div + DW'(1);
                end else begin
                    w_div = '0;
                    if (!r_tck) begin
                        w_tck = 1'b1;
                        if (r_state == SHIFT) w_rsp_data[r_cnt[IW-1:0]] = tdo;
                    end else begin
                        // Falling edge: launch the next TMS/TDI or leave the scan
                        w_tck   = 1'b0;
                        w_state = w_adv_state;
                        w_cnt   = w_adv_cnt;
                        if (w_adv_state == RESP) begin
                            w_rsp_valid = 1'b1;
                        end else if (w_adv_state != IDLE) begin
                            w_tms = tms_of(w_adv_state, w_adv_cnt, r_op_ir, r_len);
                            w_tdi = (w_adv_state == SHIFT) ? r_data[w_adv_cnt[IW-1:0]] : 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    assign tck           = r_tck;
    assign tms           = r_tms;
    assign tdi           = r_tdi;
    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - scoreboard bench for jtag_host against a 1149.1 TAP model
module tb_jtag_host;
    localparam int MAXLEN = 32;
    localparam int CLKDIV = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic tck, tms, tdi;
    logic tdo = 1'b0;

    jtag_host_if #(.MAXLEN(MAXLEN)) bus ();

    jtag_host #(.MAXLEN(MAXLEN), .CLKDIV(CLKDIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .tck     (tck),
        .tms     (tms),
        .tdi     (tdi),
        .tdo     (tdo)
    );

    always #5 clk = ~clk;

    // Target TAP: 4-bit IR capturing 0001, DR is a 1-bit bypass capturing 0
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t       tap = TLR;
    logic       bypass = 1'b0;
    logic [3:0] ir = 4'b0;

    always @(posedge tck) begin
        if (tap == CAPDR) bypass <= 1'b0;
        if (tap == SHDR)  bypass <= tdi;
        if (tap == CAPIR) ir <= 4'b0001;
        if (tap == SHIR)  ir <= {tdi, ir[3:1]};
        case (tap)
            TLR:   tap <= tms ? TLR   : RTI;
            RTI:   tap <= tms ? SELDR : RTI;
            SELDR: tap <= tms ? SELIR : CAPDR;
            CAPDR: tap <= tms ? EX1DR : SHDR;
            SHDR:  tap <= tms ? EX1DR : SHDR;
            EX1DR: tap <= tms ? UPDR  : PADR;
            PADR:  tap <= tms ? EX2DR : PADR;
            EX2DR: tap <= tms ? UPDR  : SHDR;
            UPDR:  tap <= tms ? SELDR : RTI;
            SELIR: tap <= tms ? TLR   : CAPIR;
            CAPIR: tap <= tms ? EX1IR : SHIR;
            SHIR:  tap <= tms ? EX1IR : SHIR;
            EX1IR: tap <= tms ? UPIR  : PAIR;
            PAIR:  tap <= tms ? EX2IR : PAIR;
            EX2IR: tap <= tms ? UPIR  : SHIR;
            default: tap <= tms ? SELDR : RTI;
        endcase
    end

    always @(negedge tck) tdo <= (tap == SHDR) ? bypass : (tap == SHIR) ? ir[0] : 1'b0;

    int   tck_rises = 0;
    logic tms_log[$];
    always @(posedge tck) begin
        tck_rises++;
        tms_log.push_back(tms);
    end

    int          total = 0;
    int          bad = 0;
    int          cmd_base = 0;
    logic [31:0] sb_q[$];

    function automatic logic [31:0] len_mask(input int len);
        return (len >= 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
    endfunction

    function automatic logic [63:0] tms_pattern(input logic [1:0] op, input int len, output int n);
        logic [63:0] v = '0;
        n = 0;
        if (op == 2'b00) begin
            for (int i = 0; i < 5; i++) begin v[n] = 1'b1; n++; end
            n++;
            return v;
        end
        v[n] = 1'b1; n++;
        if (op == 2'b01) begin v[n] = 1'b1; n++; end
        n += 2;
        for (int i = 0; i < len; i++) begin v[n] = (i == len - 1); n++; end
        v[n] = 1'b1; n++;
        n++;
        return v;
    endfunction

    task automatic send_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                            input logic [31:0] exp, output bit ok);
        int n = 0;
        sb_q.push_back(exp);
        @(negedge clk);
        while (!bus.cmd_ready && n < 3000) begin @(negedge clk); n++; end
        total++;
        ok = bus.cmd_ready;
        if (!ok) begin
            bad++;
            $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", bus.cmd_ready, n);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = 6'(len);
        bus.cmd_data  = data;
        @(posedge clk);
        cmd_base = tck_rises;
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 3000);
        total++;
        ok = bus.rsp_valid;
        if (!ok) begin
            bad++;
            $display("FAIL rsp_wait: rsp_valid=%0b after %0d cycles, required 1", bus.rsp_valid, n);
        end
    endtask

    task automatic ack_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic do_scan(input string name, input logic [1:0] op, input int len,
                           input logic [31:0] data, input logic [31:0] exp_data,
                           input logic [63:0] exp_tms, input int exp_n);
        bit          ok;
        logic [31:0] exp;
        logic [63:0] obs = '0;
        int          got_n;
        send_cmd(op, len, data, exp_data, ok);
        if (!ok) return;
        wait_rsp(ok);
        if (!ok) return;
        exp = sb_q.pop_front();
        total++;
        if (bus.rsp_data !== exp) begin
            bad++;
            $display("FAIL %s rsp_data: got=%h required=%h", name, bus.rsp_data, exp);
        end
        got_n = tck_rises - cmd_base;
        for (int k = 0; k < got_n && k < 64; k++) obs[k] = tms_log[cmd_base + k];
        total++;
        if (got_n !== exp_n) begin
            bad++;
            $display("FAIL %s tck_count: got=%0d required=%0d", name, got_n, exp_n);
        end
        total++;
        if (obs !== exp_tms) begin
            bad++;
            $display("FAIL %s tms_seq: got=%h required=%h", name, obs, exp_tms);
        end
        total++;
        if (tap !== RTI || tdi !== 1'b0 || tms !== 1'b0) begin
            bad++;
            $display("FAIL %s end_state: tap=%0d tdi=%0b tms=%0b, required tap=%0d tdi=0 tms=0",
                     name, tap, tdi, tms, RTI);
        end
        ack_rsp();
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s post_ack: cmd_ready=%0b rsp_valid=%0b, required 1/0",
                     name, bus.cmd_ready, bus.rsp_valid);
        end
    endtask

    task automatic check_reset_seq(input string name);
        logic [5:0] obs = '0;
        int base;
        @(posedge clk);
        #1 reset_n = 1'b1;
        base = tck_rises;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            total++;
            if (tck !== ((i % 4) >= 2) || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s phase[%0d]: tck=%0b cmd_ready=%0b rsp_valid=%0b, required tck=%0b 0 0",
                         name, i, tck, bus.cmd_ready, bus.rsp_valid, ((i % 4) >= 2));
            end
        end
        @(negedge clk);
        for (int k = 0; k < 6 && base + k < tms_log.size(); k++) obs[k] = tms_log[base + k];
        total++;
        if (bus.cmd_ready !== 1'b1 || tck !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s ready: cmd_ready=%0b tck=%0b rsp_valid=%0b, required 1 0 0",
                     name, bus.cmd_ready, tck, bus.rsp_valid);
        end
        total++;
        if (tck_rises - base !== 6 || obs !== 6'b011111 || tap !== RTI) begin
            bad++;
            $display("FAIL %s sequence: tcks=%0d tms=%b tap=%0d, required 6 011111 %0d",
                     name, tck_rises - base, obs, tap, RTI);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (tck !== 1'b0 || tms !== 1'b1 || tdi !== 1'b0 || bus.cmd_ready !== 1'b0 ||
            bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: tck=%0b tms=%0b tdi=%0b rdy=%0b rv=%0b rd=%h, required 0 1 0 0 0 0",
                     tck, tms, tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_data);
        end
        check_reset_seq("reset");
    endtask

    task automatic test_dr_bypass();
        do_scan("dr_bypass", 2'b10, 8, 32'hA5, 32'h4A, 64'h0C01, 13);
    endtask

    task automatic test_ir_scan();
        do_scan("ir_scan", 2'b01, 4, 32'hF, 32'h1, 64'h183, 10);
    endtask

    task automatic test_len_bounds();
        int n;
        logic [63:0] p;
        logic [31:0] d = $urandom;
        p = tms_pattern(2'b10, 1, n);
        do_scan("dr_len1", 2'b10, 1, 32'h1, 32'h0, p, n);
        p = tms_pattern(2'b10, 32, n);
        do_scan("dr_len32", 2'b10, 32, d, (d << 1) & len_mask(32), p, n);
        p = tms_pattern(2'b01, 8, n);
        do_scan("ir_len8", 2'b01, 8, 32'h5A, ((32'h5A << 4) | 32'h1) & len_mask(8), p, n);
    endtask

    task automatic test_tap_reset_cmd();
        do_scan("tap_reset_cmd", 2'b00, 1, 32'hFFFF_FFFF, 32'h0, 64'h1F, 6);
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] exp;
        int base;
        send_cmd(2'b10, 8, 32'h3C, 32'h78, ok);
        if (!ok) return;
        wait_rsp(ok);
        if (!ok) return;
        exp = sb_q.pop_front();
        base = tck_rises;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp || bus.cmd_ready !== 1'b0 ||
                tck_rises !== base || tck !== 1'b0) begin
                bad++;
                $display("FAIL backpressure[%0d]: rv=%0b rd=%h rdy=%0b tcks=%0d, required 1 %h 0 %0d",
                         i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, tck_rises, exp, base);
            end
            @(negedge clk);
        end
        ack_rsp();
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_release: cmd_ready=%0b rsp_valid=%0b, required 1 0",
                     bus.cmd_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        logic [31:0] exp;
        logic [1:0] ops [3] = '{2'b10, 2'b11, 2'b10};
        int         lens[3] = '{0, 8, 33};
        for (int t = 0; t < 3; t++) begin
            send_cmd(ops[t], lens[t], 32'hFFFF_FFFF, 32'h0, ok);
            if (!ok) return;
            @(negedge clk);
            exp = sb_q.pop_front();
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp) begin
                bad++;
                $display("FAIL illegal[%0d] rsp: rv=%0b rd=%h, required 1 %h", t, bus.rsp_valid, bus.rsp_data, exp);
            end
            total++;
            if (tck_rises !== cmd_base || tck !== 1'b0 || tms !== 1'b0 || tdi !== 1'b0) begin
                bad++;
                $display("FAIL illegal[%0d] pins: tcks=%0d tck=%0b tms=%0b tdi=%0b, required %0d 0 0 0",
                         t, tck_rises, tck, tms, tdi, cmd_base);
            end
            ack_rsp();
        end
    endtask

    task automatic test_back_to_back();
        int n, len;
        logic [63:0] p;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            len = $urandom_range(1, 32);
            d = $urandom;
            p = tms_pattern(2'b10, len, n);
            do_scan("back_to_back", 2'b10, len, d, (d << 1) & len_mask(len), p, n);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int n = 0;
        send_cmd(2'b10, 8, 32'hFF, 32'h1FE & len_mask(8), ok);
        if (!ok) return;
        while ((tck_rises - cmd_base) < 7 && n < 3000) begin @(negedge clk); n++; end
        total++;
        if (tck_rises - cmd_base !== 7) begin
            bad++;
            $display("FAIL abort_reach: tcks=%0d, required 7", tck_rises - cmd_base);
        end
        reset_n = 1'b0;
        void'(sb_q.pop_front());
        #1;
        total++;
        if (tck !== 1'b0 || tms !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_pins: tck=%0b tms=%0b rv=%0b rdy=%0b, required 0 1 0 0",
                     tck, tms, bus.rsp_valid, bus.cmd_ready);
        end
        check_reset_seq("abort");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_rsp[%0d]: rsp_valid=%0b, required 0", i, bus.rsp_valid);
            end
        end
        do_scan("after_abort", 2'b10, 8, 32'hA5, 32'h4A, 64'h0C01, 13);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        #2 reset_n = 1'b0;
        test_reset();
        test_dr_bypass();
        test_ir_scan();
        test_len_bounds();
        test_tap_reset_cmd();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtag_host.md
Name: jtag_host

Overview:
- Test-side JTAG driver (TAP master) that generates TCK/TMS/TDI and samples TDO. It scans instruction and data registers in 1149.1 targets (bypass, IDCODE, boundary-scan, debug DR).
- Driven from the system clock by a valid/ready command interface. Returns captured TDO bits through a valid/ready response interface.
- Used by the on-chip self-test and by the simulation harness to exercise target TAPs.

Parameters:
- MAXLEN, 32: maximum scan length in bits; width of cmd_data and rsp_data.
- CLKDIV, 2: clk cycles per TCK half-period (≥1). TCK period is 2*CLKDIV clk cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  host accepts command
- cmd_op  in  2  00 = TAP reset, 01 = IR scan, 10 = DR scan, 11 = reserved
- cmd_len  in  $clog2(MAXLEN+1)  scan length in bits; legal range 1..MAXLEN
- cmd_data  in  MAXLEN  TDI bits, LSB shifted first
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  MAXLEN  captured TDO; bit i is the i-th bit sampled; bits ≥ len are 0
- tck  out  1  test clock
- tms  out  1  test mode select
- tdi  out  1  test data to target
- tdo  in  1  test data from target

Behaviour:
- Reset (async assert): tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0. Any scan in progress is abandoned immediately.
- On reset release, the host runs the TAP reset sequence autonomously, with no response generated. cmd_ready first rises after that sequence completes.
- TCK generation:
  - TCK is low while idle.
  - Each TCK cycle is a low phase of CLKDIV clk cycles followed by a high phase of CLKDIV clk cycles.
  - tms/tdi change only at the start of the low phase, i.e. on the falling edge or on scan start.
  - tdo is sampled on the clk edge that drives tck high.
- FSM states: RSTSEQ, IDLE, HEAD, SHIFT, TAIL, RESP.
  - IDLE: cmd_ready=1 iff rsp_valid=0. Accept on cmd_valid&cmd_ready; latch op/len/data.
  - HEAD, DR scan: TMS 1,0,0 (Idle → Select-DR → Capture-DR → Shift-DR).
  - HEAD, IR scan: TMS 1,1,0,0 (adds Select-IR).
  - SHIFT: len TCKs. tdi = data[i]. TMS=0 for bits 0..len-2 and TMS=1 on bit len-1 (enters Exit1). TDO is sampled on every SHIFT TCK into rsp_data[i].
  - TAIL: TMS 1,0 (Update → Run-Test/Idle).
  - RSTSEQ (op 00, or after reset release): TMS 1×5 then 0×1, 6 TCKs total, ending in Run-Test/Idle. rsp_data=0.
  - RESP: rsp_valid=1 from the clk after the final TCK high phase ends. rsp_valid and rsp_data are held until rsp_valid&rsp_ready, then the FSM returns to IDLE.
- TCK counts: DR = len+5; IR = len+6; reset = 6.
- Illegal command (len=0, len>MAXLEN, or op=11): accepted, no TCK activity, tms/tdi unchanged; rsp_valid=1 the next clk with rsp_data=0.
- tdi returns to 0 and tms holds its TAIL value (0) between commands.
- The response is the only way a command completes. A new command is never accepted while rsp_valid=1, so command and response are strictly alternating.

Test Plan:
- Reset release, CLKDIV=2: exactly 6 TCK pulses with TMS 1,1,1,1,1,0, each TCK 4 clk long, 2 low and 2 high -> cmd_ready rises after the 6th pulse, rsp_valid stays 0.
- DR scan through a bypass target, op=10, len=8, data=0xA5 -> 13 TCKs; TMS sequence 1,0,0,0×7,1,1,0; rsp_data=0x4A (bypass captures 0, so bit 0 = 0 and rsp_data[i] = data[i-1]).
- IR scan, len=4, data=0xF, target IR capture value 0b0001 -> 10 TCKs, TMS 1,1,0,0,0,0,0,1,1,0; rsp_data=0x1.
- Backpressure: complete a DR scan with rsp_ready=0 for 20 clk -> rsp_valid and rsp_data stable, cmd_ready=0, no TCK. Then rsp_ready=1 -> cmd_ready=1 the next clk.
- Illegal command, len=0 and separately op=11 -> zero TCK edges, rsp_valid the next clk, rsp_data=0.
- reset_n asserted mid-SHIFT (bit 3 of 8) -> tck=0, tms=1, rsp_valid=0 immediately. After release, a 6-TCK reset sequence is emitted and no response is issued for the aborted scan.
